// File: rtl/alpha_block_v3_pkg.sv
// alpha_pkg: shared definitions for the alpha gain-select block.
//   - state_e        : FSM state encoding (HOLD=0, ARMED=1, LOW=2), also exported on state_o
//   - *_DEF          : default parameter values used by the block, its interface and sub-modules
package alpha_pkg;

    localparam int DATA_W_DEF    = 9;
    localparam int TIMEOUT_W_DEF = 18;
    localparam int MASK_W_DEF    = 5;
    localparam int HOLD_W_DEF    = 8;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOW   = 2'd2
    } state_e;

endpackage

// File: rtl/alpha_block_v3_if.sv
// alpha_block_v3_if: sample/configuration/status bundle of the alpha block.
//   master modport : sample source / configuration owner (drives strobe, sample, thresholds, mask, holdoff)
//   slave modport  : the alpha block (drives alpha, alpha_changed, state_o)
interface alpha_block_v3_if
    import alpha_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MASK_W = MASK_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
);
    logic              enable_sampling;
    logic [DATA_W-1:0] hdr_current_value;
    logic [DATA_W-1:0] threshold_high;
    logic [DATA_W-1:0] threshold_low;
    logic [MASK_W-1:0] timeout_mask;
    logic [HOLD_W-1:0] holdoff_samples;
    logic              alpha;
    logic              alpha_changed;
    logic [1:0]        state_o;

    modport master (
        output enable_sampling, hdr_current_value, threshold_high, threshold_low,
               timeout_mask, holdoff_samples,
        input  alpha, alpha_changed, state_o
    );

    modport slave (
        input  enable_sampling, hdr_current_value, threshold_high, threshold_low,
               timeout_mask, holdoff_samples,
        output alpha, alpha_changed, state_o
    );
endinterface

// File: rtl/alpha_block_v3_sat_counter.sv
// alpha_sat_counter: saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   en         : update strobe; count holds when low
//   clr        : clear to zero (wins over inc)
//   inc        : increment by one, sticking at all-ones
//   count      : registered count value
module alpha_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_nxt_s;

    // Next count: clear first, then saturating increment, otherwise hold.
    always_comb begin
        count_nxt_s = count;
        if (clr) begin
            count_nxt_s = ZERO;
        end else if (inc && !(&count)) begin
            count_nxt_s = count + ONE;
        end else begin
            count_nxt_s = count;
        end
    end

    // Count register, advancing only on strobed edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= ZERO;
        end else if (en) begin
            count <= count_nxt_s;
        end else begin
            count <= count;
        end
    end
endmodule

// File: rtl/alpha_block_v3.sv
// alpha_block_v3: selects a safe (alpha=1) or low (alpha=0) gain from a signed sample stream.
// The magnitude must stay out of the above-threshold band for holdoff_samples samples
// (HOLD), then accumulate enough below-threshold samples (ARMED) to hit a masked top
// bit of the timeout counter before gain drops (LOW). Any above sample returns to HOLD.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of alpha_block_v3_if (strobe, sample, thresholds, mask,
//                holdoff in; alpha, alpha_changed, state_o out, all registered)
module alpha_block_v3
    import alpha_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF,
    parameter int MASK_W    = MASK_W_DEF,
    parameter int HOLD_W    = HOLD_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    alpha_block_v3_if.slave  bus
);
    localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    // Saturating increment used to predict the timeout count of the current sample.
    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [DATA_W-1:0]    mag_s;
    logic                 above_s;
    logic                 below_s;
    logic [HOLD_W-1:0]    hold_cnt_s;
    logic [TIMEOUT_W-1:0] timeout_cnt_s;
    logic [TIMEOUT_W-1:0] armed_tmo_nxt_s;
    logic                 timeout_hit_s;
    state_e               state_r;
    state_e               state_nxt_s;
    logic                 hold_clr_s;
    logic                 hold_inc_s;
    logic                 tmo_clr_s;
    logic                 tmo_inc_s;
    logic                 alpha_r;
    logic                 alpha_nxt_s;
    logic                 alpha_changed_r;
    logic                 alpha_changed_nxt_s;

    // Two's-complement magnitude; the most negative value maps to 2^(DATA_W-1) in unsigned form.
    always_comb begin
        if (bus.hdr_current_value[DATA_W-1]) begin
            mag_s = ~bus.hdr_current_value + DATA_ONE;
        end else begin
            mag_s = bus.hdr_current_value;
        end
        above_s = (mag_s > bus.threshold_high);
        below_s = (mag_s < bus.threshold_low);
    end

    // Timeout count this sample would produce in ARMED, and whether it reaches a masked bit.
    always_comb begin
        if (below_s) begin
            armed_tmo_nxt_s = sat_inc(timeout_cnt_s);
        end else begin
            armed_tmo_nxt_s = timeout_cnt_s;
        end
        timeout_hit_s = |(armed_tmo_nxt_s[TIMEOUT_W-1 -: MASK_W] & bus.timeout_mask);
    end

    // Next-state and counter control; above always has priority over below.
    always_comb begin
        state_nxt_s = state_r;
        hold_clr_s  = 1'b0;
        hold_inc_s  = 1'b0;
        tmo_clr_s   = 1'b0;
        tmo_inc_s   = 1'b0;
        case (state_r)
            ST_HOLD: begin
                if (above_s) begin
                    hold_clr_s = 1'b1;
                end else if (hold_cnt_s >= bus.holdoff_samples) begin
                    state_nxt_s = ST_ARMED;
                    tmo_clr_s   = 1'b1;
                end else begin
                    hold_inc_s = 1'b1;
                end
            end
            ST_ARMED: begin
                if (above_s) begin
                    state_nxt_s = ST_HOLD;
                    hold_clr_s  = 1'b1;
                    tmo_clr_s   = 1'b1;
                end else begin
                    tmo_inc_s = below_s;
                    if (timeout_hit_s) begin
                        state_nxt_s = ST_LOW;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
            end
            ST_LOW: begin
                if (above_s) begin
                    state_nxt_s = ST_HOLD;
                    hold_clr_s  = 1'b1;
                    tmo_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_LOW;
                end
            end
            default: begin
                state_nxt_s = ST_HOLD;
                hold_clr_s  = 1'b1;
                tmo_clr_s   = 1'b1;
            end
        endcase
    end

    // Output decode: alpha follows the next state so it changes on the same edge as the state.
    always_comb begin
        if (state_nxt_s == ST_LOW) begin
            alpha_nxt_s = 1'b0;
        end else begin
            alpha_nxt_s = 1'b1;
        end
        alpha_changed_nxt_s = bus.enable_sampling & (alpha_nxt_s != alpha_r);
    end

    // State, alpha and change-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_HOLD;
            alpha_r         <= 1'b1;
            alpha_changed_r <= 1'b0;
        end else if (bus.enable_sampling) begin
            state_r         <= state_nxt_s;
            alpha_r         <= alpha_nxt_s;
            alpha_changed_r <= alpha_changed_nxt_s;
        end else begin
            state_r         <= state_r;
            alpha_r         <= alpha_r;
            alpha_changed_r <= 1'b0;
        end
    end

    alpha_sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (bus.enable_sampling),
        .clr   (hold_clr_s),
        .inc   (hold_inc_s),
        .count (hold_cnt_s)
    );

    alpha_sat_counter #(.WIDTH(TIMEOUT_W)) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (bus.enable_sampling),
        .clr   (tmo_clr_s),
        .inc   (tmo_inc_s),
        .count (timeout_cnt_s)
    );

    assign bus.alpha         = alpha_r;
    assign bus.alpha_changed = alpha_changed_r;
    assign bus.state_o       = state_r;
endmodule
